// File: rtl/key_step_ctrl.sv
// Debounced push-button single-step / free-run clock generator for a processor clock input.
// Produces a clean registered step_clk plus edge count, overrun flag and busy indication.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a debounced press or run request
// HIGH    | single-step high phase, HI_CYCLES long
// LOW_GAP | enforced low time after a step or after run is stopped
// RUN_HI  | free-run high phase, H cycles (always completes)
// RUN_LO  | free-run low phase, H cycles (aborted when run drops)
module key_step_ctrl #(
  parameter int DB_CYCLES = 1000000,
  parameter int HI_CYCLES = 1000
) (
  input  logic        CLOCK_50,
  input  logic        SYS_rst,
  input  logic        key_n,
  input  logic        run_mode,
  input  logic [1:0]  rate_sel,
  input  logic        ovr_clr,
  output logic        step_clk,
  output logic [15:0] step_cnt,
  output logic        overrun,
  output logic        busy
);

  localparam int DBW = $clog2(DB_CYCLES);
  // Enough timer bits for the slowest free-run phase, HI_CYCLES << 6.
  localparam int TW = $clog2(HI_CYCLES) + 6;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  HI_LOAD = TW'(HI_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, HIGH, LOW_GAP, RUN_HI, RUN_LO} state_t;

  logic [1:0]     key_sync;
  logic [1:0]     run_sync;
  logic           key_s;
  logic           run_s;
  logic           key_db;
  logic [DBW-1:0] dbc;
  logic           press_evt;

  state_t         state;
  state_t         nxt;
  logic [TW-1:0]  tmr;
  logic [TW-1:0]  tmr_nxt;
  logic [TW-1:0]  run_len;
  logic [TW-1:0]  run_load;
  logic           ovr_set;
  logic           cnt_inc;

  assign key_s = key_sync[1];
  assign run_s = run_sync[1];

  always_ff @(posedge CLOCK_50 or negedge SYS_rst) begin
    if (!SYS_rst) begin
      key_sync <= '0;
      run_sync <= '0;
    end else begin
      key_sync <= {key_sync[0], ~key_n};
      run_sync <= {run_sync[0], run_mode};
    end
  end

  // Any bounce returns the key to the accepted level and restarts the count.
  always_ff @(posedge CLOCK_50 or negedge SYS_rst) begin
    if (!SYS_rst) begin
      key_db    <= 1'b0;
      dbc       <= '0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= (key_s != key_db) && (dbc == DB_LAST) && key_s;
      if (key_s == key_db) begin
        dbc <= '0;
      end else if (dbc == DB_LAST) begin
        key_db <= key_s;
        dbc    <= '0;
      end else begin
        dbc <= dbc + DBW'(1);
      end
    end
  end

  assign run_len  = TW'(HI_CYCLES) << {rate_sel, 1'b0};
  assign run_load = run_len - TW'(1);

  always_comb begin
    nxt     = state;
    tmr_nxt = tmr;
    ovr_set = 1'b0;
    case (state)
      IDLE: begin
        if (run_s) begin
          nxt     = RUN_HI;
          tmr_nxt = run_load;
        end else if (press_evt) begin
          nxt     = HIGH;
          tmr_nxt = HI_LOAD;
        end
      end
      HIGH: begin
        ovr_set = press_evt;
        if (tmr == '0) begin
          nxt     = LOW_GAP;
          tmr_nxt = HI_LOAD;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      LOW_GAP: begin
        ovr_set = press_evt;
        if (tmr == '0) begin
          nxt = IDLE;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      RUN_HI: begin
        if (tmr == '0) begin
          if (run_s) begin
            nxt     = RUN_LO;
            tmr_nxt = run_load;
          end else begin
            nxt     = LOW_GAP;
            tmr_nxt = HI_LOAD;
          end
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      RUN_LO: begin
        if (!run_s) begin
          nxt = IDLE;
        end else if (tmr == '0) begin
          nxt     = RUN_HI;
          tmr_nxt = run_load;
        end else begin
          tmr_nxt = tmr - TW'(1);
        end
      end
      default: begin
        nxt     = IDLE;
        tmr_nxt = '0;
      end
    endcase
  end

  assign cnt_inc = ((nxt == HIGH) && (state != HIGH)) ||
                   ((nxt == RUN_HI) && (state != RUN_HI));

  // step_clk is decoded from the next state so it is a flop output, glitch-free.
  always_ff @(posedge CLOCK_50 or negedge SYS_rst) begin
    if (!SYS_rst) begin
      state    <= IDLE;
      tmr      <= '0;
      step_clk <= 1'b0;
      step_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      state    <= nxt;
      tmr      <= tmr_nxt;
      step_clk <= (nxt == HIGH) || (nxt == RUN_HI);
      if (cnt_inc) begin
        step_cnt <= step_cnt + 16'd1;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_key_step_ctrl.sv
// Self-checking bench for key_step_ctrl with DB_CYCLES=4, HI_CYCLES=2: vector tables,
// hand-timed corner sequences and a randomized key stream against an interval-based model.
module tb_key_step_ctrl;

  localparam int DB = 4;
  localparam int HI = 2;

  logic        CLOCK_50 = 1'b0;
  logic        SYS_rst  = 1'b0;
  logic        key_n    = 1'b1;
  logic        run_mode = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic        ovr_clr  = 1'b0;
  logic        step_clk;
  logic [15:0] step_cnt;
  logic        overrun;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  key_step_ctrl #(.DB_CYCLES(DB), .HI_CYCLES(HI)) dut (
    .CLOCK_50 (CLOCK_50),
    .SYS_rst  (SYS_rst),
    .key_n    (key_n),
    .run_mode (run_mode),
    .rate_sel (rate_sel),
    .ovr_clr  (ovr_clr),
    .step_clk (step_clk),
    .step_cnt (step_cnt),
    .overrun  (overrun),
    .busy     (busy)
  );

  typedef struct {
    logic        key_n;
    logic        step_clk;
    logic        busy;
    logic [15:0] cnt;
  } ss_vec_t;

  typedef struct {
    logic [1:0] rate;
    int         half;
  } rate_vec_t;

  ss_vec_t   ss_tab[12];
  rate_vec_t rate_tab[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50)
        $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic cyc(input logic kn, input logic rm, input logic clr);
    key_n    = kn;
    run_mode = rm;
    ovr_clr  = clr;
    @(posedge CLOCK_50);
    edge_n++;
    @(negedge CLOCK_50);
  endtask

  task automatic do_reset();
    SYS_rst  = 1'b0;
    key_n    = 1'b1;
    run_mode = 1'b0;
    ovr_clr  = 1'b0;
    rate_sel = 2'd0;
    repeat (3) @(negedge CLOCK_50);
    SYS_rst = 1'b1;
    edge_n  = 0;
  endtask

  task automatic run_len(input logic lvl, input int limit, output int n);
    n = 0;
    while (step_clk === lvl && n < limit) begin
      cyc(key_n, run_mode, ovr_clr);
      n++;
    end
  endtask

  // Reference model state for the randomized single-step run.
  bit sync_q[$];
  int db_lvl, mis, evt_pend, s_start, cnt_m, ovr_m;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, h1, l1, h2, n, highs, x, seg, ks, evt, new_evt, set;
    logic kn, clr;

    ss_tab = '{
      '{1'b0, 1'b0, 1'b0, 16'd0}, '{1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b0, 1'b0, 1'b0, 16'd0}, '{1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b0, 1'b0, 1'b0, 16'd0}, '{1'b0, 1'b0, 1'b0, 16'd0},
      '{1'b0, 1'b1, 1'b1, 16'd1}, '{1'b0, 1'b1, 1'b1, 16'd1},
      '{1'b0, 1'b0, 1'b1, 16'd1}, '{1'b0, 1'b0, 1'b1, 16'd1},
      '{1'b0, 1'b0, 1'b0, 16'd1}, '{1'b0, 1'b0, 1'b0, 16'd1}
    };
    rate_tab = '{'{2'd0, 2}, '{2'd1, 8}, '{2'd2, 32}, '{2'd3, 128}};

    // Reset state
    @(negedge CLOCK_50);
    check("rst_step_clk", step_clk, 0);
    check("rst_busy", busy, 0);
    check("rst_step_cnt", step_cnt, 0);
    check("rst_overrun", overrun, 0);

    // Single step from a held key
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cyc(ss_tab[k].key_n, 1'b0, 1'b0);
      check("ss_step_clk", step_clk, ss_tab[k].step_clk);
      check("ss_busy", busy, ss_tab[k].busy);
      check("ss_step_cnt", step_cnt, ss_tab[k].cnt);
    end
    repeat (10) cyc(1'b1, 1'b0, 1'b0);
    check("ss_release_cnt", step_cnt, 1);
    check("ss_release_busy", busy, 0);

    // Bounce shorter than the debounce window
    do_reset();
    highs = 0;
    for (int k = 0; k < 22; k++) begin
      cyc((k < 3 || (k >= 4 && k < 7)) ? 1'b0 : 1'b1, 1'b0, 1'b0);
      if (step_clk !== 1'b0) highs++;
    end
    check("bounce_pulses", highs, 0);
    check("bounce_cnt", step_cnt, 0);
    check("bounce_overrun", overrun, 0);

    // Overrun: presses landing in LOW_GAP after a stopped run, then clear vs set
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      cyc((e <= 7 || e >= 12) ? 1'b0 : 1'b1,
          (e <= 2 || e == 12 || e == 13) ? 1'b1 : 1'b0,
          (e == 18 || e == 19) ? 1'b1 : 1'b0);
      if (e == 4) check("ovr_run_high", step_clk, 1);
      if (e == 6) begin
        check("ovr_gap_busy", busy, 1);
        check("ovr_before_drop", overrun, 0);
      end
      if (e == 7) begin
        check("ovr_set", overrun, 1);
        check("ovr_cnt_kept", step_cnt, 1);
        check("ovr_idle", busy, 0);
      end
      if (e == 18) begin
        check("ovr_set_wins", overrun, 1);
        check("ovr_cnt2", step_cnt, 2);
      end
      if (e == 19) check("ovr_cleared", overrun, 0);
    end

    // Free-run period per rate_sel
    for (int i = 0; i < 4; i++) begin
      do_reset();
      rate_sel = rate_tab[i].rate;
      run_mode = 1'b1;
      run_len(1'b0, 20, w);
      run_len(1'b1, 300, h1);
      run_len(1'b0, 300, l1);
      run_len(1'b1, 300, h2);
      check("run_high1", h1, rate_tab[i].half);
      check("run_low", l1, rate_tab[i].half);
      check("run_high2", h2, rate_tab[i].half);
      check("run_cnt", step_cnt, 2);
    end

    // Run dropped mid-high: high completes, then HI_CYCLES low, then idle
    do_reset();
    rate_sel = 2'd1;
    run_mode = 1'b1;
    run_len(1'b0, 20, w);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run_mode = 1'b0;
    run_len(1'b1, 50, h1);
    check("drop_high_len", h1 + 2, 8);
    n = 0;
    while (busy === 1'b1 && step_clk === 1'b0 && n < 20) begin
      cyc(1'b1, 1'b0, 1'b0);
      n++;
    end
    check("drop_gap_len", n, HI);
    highs = 0;
    repeat (20) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (step_clk !== 1'b0) highs++;
    end
    check("drop_stays_idle", highs, 0);
    check("drop_busy", busy, 0);

    // Counter wrap, then reset mid-pulse and re-debounce of a held key
    do_reset();
    force dut.step_cnt = 16'hFFFF;
    #1;
    release dut.step_cnt;
    check("wrap_preload", step_cnt, 16'hFFFF);
    for (int e = 1; e <= 7; e++) cyc(1'b0, 1'b0, 1'b0);
    check("wrap_high", step_clk, 1);
    check("wrap_cnt", step_cnt, 0);
    cyc(1'b0, 1'b0, 1'b0);
    #2;
    SYS_rst = 1'b0;
    #1;
    check("arst_step_clk", step_clk, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt", step_cnt, 0);
    check("arst_overrun", overrun, 0);
    @(negedge CLOCK_50);
    SYS_rst = 1'b1;
    edge_n  = 0;
    for (int e = 1; e <= 7; e++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (e == 6) check("redb_low_e6", step_clk, 0);
      if (e == 7) check("redb_high_e7", step_clk, 1);
    end

    // Randomized key stream against interval model
    do_reset();
    sync_q   = {1'b0, 1'b0};
    db_lvl   = 0;
    mis      = 0;
    evt_pend = 0;
    s_start  = -100;
    cnt_m    = 0;
    ovr_m    = 0;
    seg      = 0;
    kn       = 1'b1;
    for (int c = 0; c < 2500; c++) begin
      if (seg == 0) begin
        kn  = ($urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
        seg = $urandom_range(1, 10);
      end
      seg--;
      clr = ($urandom_range(0, 29) == 0) ? 1'b1 : 1'b0;
      x   = edge_n + 1;
      // synchronized level seen this edge is the pressed level from two edges earlier
      ks = int'(sync_q.pop_front());
      sync_q.push_back(~kn);
      evt     = evt_pend;
      new_evt = 0;
      if (ks != db_lvl) mis++;
      else mis = 0;
      if (mis == DB) begin
        db_lvl  = ks;
        mis     = 0;
        new_evt = ks;
      end
      set = 0;
      if (evt != 0) begin
        if ((x - 1) >= s_start && (x - 1) <= s_start + 2 * HI - 1) set = 1;
        else begin
          s_start = x;
          cnt_m   = (cnt_m + 1) & 16'hFFFF;
        end
      end
      if (set != 0) ovr_m = 1;
      else if (clr) ovr_m = 0;
      evt_pend = new_evt;
      cyc(kn, 1'b0, clr);
      check("rnd_step_clk", step_clk, (x >= s_start && x <= s_start + HI - 1) ? 1 : 0);
      check("rnd_busy", busy, (x >= s_start && x <= s_start + 2 * HI - 1) ? 1 : 0);
      check("rnd_step_cnt", step_cnt, cnt_m);
      check("rnd_overrun", overrun, ovr_m);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
